// File: rtl/dcpu16_bus_arb.sv
// DCPU-16 memory port arbiter: shares one simplified-Wishbone slave
// between the fetch bus (F) and the operand/EA bus (G).
module dcpu16_bus_arb #(
    parameter int PRIO = 0,
    parameter int TMO  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack,
    output logic        f_err,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_dto,
    output logic [15:0] g_dti,
    output logic        g_ack,
    output logic        g_err,
    output logic [15:0] m_adr,
    output logic        m_stb,
    output logic        m_wre,
    output logic [15:0] m_dto,
    input  logic [15:0] m_dti,
    input  logic        m_ack,
    output logic [1:0]  gnt
);

    // State encoding doubles as the gnt output value
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_F = 2'b01,
        GNT_G = 2'b10
    } state_t;

    localparam bit         TMO_EN   = (TMO > 0);
    localparam logic [7:0] TMO_LAST = (TMO > 0) ? 8'(TMO - 1) : 8'd0;

    state_t      r_state;
    state_t      w_nxt;
    logic [7:0]  r_cnt;
    logic        r_last_g;
    logic [15:0] r_m_adr;
    logic        r_m_stb;
    logic        r_m_wre;
    logic [15:0] r_m_dto;

    logic w_own_f;
    logic w_own_g;
    logic w_busy;
    logic w_tmo;
    logic w_done;
    logic w_arb;
    logic w_req_f;
    logic w_req_g;
    logic w_g_tie;
    logic w_pick_f;
    logic w_pick_g;

    // Ownership, completion/timeout detection and arbitration decision
    always_comb begin
        w_own_f = (r_state == GNT_F);
        w_own_g = (r_state == GNT_G);
        w_busy  = w_own_f || w_own_g;
        w_tmo   = TMO_EN && w_busy && !m_ack && (r_cnt == TMO_LAST);
        w_done  = w_busy && (m_ack || w_tmo);
        w_arb   = (r_state == IDLE) || w_done;
        // The finishing owner still holds stb high; ignore it this cycle
        w_req_f = f_stb && !w_own_f;
        w_req_g = g_stb && !w_own_g;
        // Round-robin: G wins a tie only if F was served last
        w_g_tie  = (PRIO != 0) || !r_last_g;
        w_pick_g = w_arb && w_req_g && (!w_req_f || w_g_tie);
        w_pick_f = w_arb && w_req_f && !w_pick_g;
    end

    // Next-state selection
    always_comb begin
        w_nxt = r_state;
        if (w_pick_f) begin
            w_nxt = GNT_F;
        end else if (w_pick_g) begin
            w_nxt = GNT_G;
        end else if (w_arb) begin
            w_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Registered memory request, loaded from the winner on each grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_adr <= 16'h0000;
            r_m_stb <= 1'b0;
            r_m_wre <= 1'b0;
            r_m_dto <= 16'h0000;
        end else if (w_pick_f) begin
            r_m_adr <= f_adr;
            r_m_stb <= 1'b1;
            r_m_wre <= f_wre;
            r_m_dto <= f_dto;
        end else if (w_pick_g) begin
            r_m_adr <= g_adr;
            r_m_stb <= 1'b1;
            r_m_wre <= g_wre;
            r_m_dto <= g_dto;
        end else if (w_done) begin
            r_m_stb <= 1'b0;
        end
    end

    // Saturating wait counter for the hung-cycle timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (w_pick_f || w_pick_g) begin
            r_cnt <= 8'd0;
        end else if (w_busy && !m_ack && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Round-robin pointer: remembers who finished last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_g <= 1'b1;
        end else if (w_done) begin
            r_last_g <= w_own_g;
        end
    end

    assign m_adr = r_m_adr;
    assign m_stb = r_m_stb;
    assign m_wre = r_m_wre;
    assign m_dto = r_m_dto;
    assign gnt   = r_state;

    assign f_ack = w_own_f && m_ack;
    assign g_ack = w_own_g && m_ack;
    assign f_err = w_own_f && w_tmo;
    assign g_err = w_own_g && w_tmo;
    assign f_dti = w_own_f ? m_dti : 16'h0000;
    assign g_dti = w_own_g ? m_dti : 16'h0000;

endmodule
